// File: rtl/alu_pkg.sv
// Shared operation codes and FSM state encoding for aludec and the execute stage.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0110,
        OP_SLT = 4'b0111,
        OP_NOR = 4'b1100,
        OP_MUL = 4'b1000,
        OP_DIV = 4'b1001
    } aluctrl_t;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t BUSY = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU operations; codes without a single-cycle meaning give 0.
module alu_comb
    import alu_pkg::*;
#(
    parameter int n = 32
) (
    input  logic [3:0]   aluctrl,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] y
);

    always_comb begin
        y = '0;
        case (aluctrl)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_SLT:  y = {{(n-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_NOR:  y = ~(a | b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_iter.sv
// Execute stage: single-cycle ops via alu_comb, MUL/DIV iterate one bit per cycle.
//  state | meaning
//  IDLE  | ready to accept an op
//  BUSY  | MUL/DIV stepping, count runs n-1 down to 0
//  DONE  | result/zero valid, waiting for out_ready
module alu_iter
    import alu_pkg::*;
#(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   aluctrl,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] result,
    output logic         zero
);

    localparam int CW = $clog2(n);

    state_t        state;
    logic [CW-1:0] count;
    logic          is_div;
    logic [n:0]    acc;      // MUL product / DIV remainder (n+1 bits)
    logic [n-1:0]  opa;      // MUL multiplicand / DIV divisor
    logic [n-1:0]  opb;      // MUL multiplier / DIV dividend shifting into quotient

    logic [n-1:0]  comb_y;
    logic [n-1:0]  single_y;
    logic [n:0]    rem_sh;
    logic [n:0]    diff;
    logic [n:0]    acc_nx;
    logic [n-1:0]  opa_nx;
    logic [n-1:0]  opb_nx;
    logic [n-1:0]  fin;

    alu_comb #(.n(n)) u_comb (
        .aluctrl (aluctrl),
        .a       (a),
        .b       (b),
        .y       (comb_y)
    );

    // only reached for DIV when b==0, otherwise the op is single-cycle
    assign single_y = (aluctrl == OP_DIV) ? '1 : comb_y;

    always_comb begin
        rem_sh = {acc[n-1:0], opb[n-1]};
        diff   = rem_sh - {1'b0, opa};
        acc_nx = acc;
        opa_nx = opa;
        opb_nx = opb;
        if (is_div) begin
            if (!diff[n]) begin
                acc_nx = diff;
                opb_nx = {opb[n-2:0], 1'b1};
            end else begin
                acc_nx = rem_sh;
                opb_nx = {opb[n-2:0], 1'b0};
            end
        end else begin
            if (opb[0]) acc_nx = acc + {1'b0, opa};
            opa_nx = opa << 1;
            opb_nx = opb >> 1;
        end
        fin = is_div ? opb_nx : acc_nx[n-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            is_div <= 1'b0;
            acc    <= '0;
            opa    <= '0;
            opb    <= '0;
            result <= '0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (aluctrl == OP_MUL) begin
                            state  <= BUSY;
                            is_div <= 1'b0;
                            acc    <= '0;
                            opa    <= a;
                            opb    <= b;
                            count  <= CW'(n - 1);
                        end else if (aluctrl == OP_DIV && b != '0) begin
                            state  <= BUSY;
                            is_div <= 1'b1;
                            acc    <= '0;
                            opa    <= b;
                            opb    <= a;
                            count  <= CW'(n - 1);
                        end else begin
                            state  <= DONE;
                            result <= single_y;
                            zero   <= (single_y == '0);
                        end
                    end
                end
                BUSY: begin
                    acc   <= acc_nx;
                    opa   <= opa_nx;
                    opb   <= opb_nx;
                    count <= count - 1'b1;
                    if (count == '0) begin
                        state  <= DONE;
                        result <= fin;
                        zero   <= (fin == '0);
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter: directed table, handshake corner cases, random ops vs model.
module tb_alu_iter;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   aluctrl = 4'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] result;
    logic         zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_iter #(.n(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluctrl   (aluctrl),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        z;
        int          lat;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: plain arithmetic on the operation's meaning.
    task automatic model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output int lat);
        longint unsigned p;
        lat = 1;
        case (op)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b0010: r = 32'(longint'(x) + longint'(y));
            4'b0110: r = 32'(longint'(x) - longint'(y));
            4'b0111: r = (int'(x) < int'(y)) ? 32'd1 : 32'd0;
            4'b1100: r = ~(x | y);
            4'b1000: begin
                p = longint'(x) * longint'(y);
                r = p[31:0];
                lat = N + 1;
            end
            4'b1001: begin
                if (y == 0) r = 32'hFFFF_FFFF;
                else begin
                    r = x / y;
                    lat = N + 1;
                end
            end
            default: r = 32'h0;
        endcase
    endtask

    // Issue one op, wait for out_valid (bounded), return what was seen, then complete handshake.
    task automatic do_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic z, output int lat,
                         output bit rdy_bad, output bit tmo);
        int k;
        @(negedge clk);
        k = 0;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        in_valid = 1'b1;
        aluctrl  = op;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
        // garbage while the op is in flight must be ignored
        aluctrl = 4'($urandom);
        a       = $urandom;
        b       = $urandom;
        rdy_bad = 1'b0;
        lat = 1;
        @(negedge clk);
        if (in_ready) rdy_bad = 1'b1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
            if (in_ready) rdy_bad = 1'b1;
        end
        tmo = !out_valid;
        r = result;
        z = zero;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input logic [3:0] op,
                                 input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] er, input logic ez, input int elat);
        logic [31:0] r;
        logic        z;
        int          lat;
        bit          rdy_bad, tmo;
        do_op(op, x, y, r, z, lat, rdy_bad, tmo);
        if (tmo) begin
            errors++;
            checks++;
            $display("FAIL %s timeout: out_valid never rose", tag);
        end else begin
            chk({tag, " result"}, r, er);
            chk({tag, " zero"}, {31'b0, z}, {31'b0, ez});
            chk({tag, " latency"}, lat, elat);
            chk({tag, " in_ready low"}, {31'b0, rdy_bad}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] er, ra, rb;
        logic [3:0]  op;
        int          elat, k;
        bit          stable, rdy_seen;
        logic [3:0]  codes[10];

        tbl[0]  = '{4'b0010, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1};
        tbl[1]  = '{4'b0110, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0, 1};
        tbl[2]  = '{4'b0111, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1};
        tbl[3]  = '{4'b0111, 32'h1,         32'hFFFF_FFFF, 32'h0,         1'b1, 1};
        tbl[4]  = '{4'b1000, 32'd1234,      32'd5678,      32'd7006652,   1'b0, 33};
        tbl[5]  = '{4'b1001, 32'd100,       32'd7,         32'd14,        1'b0, 33};
        tbl[6]  = '{4'b1001, 32'd100,       32'd0,         32'hFFFF_FFFF, 1'b0, 1};
        tbl[7]  = '{4'b1111, 32'h1234,      32'h5678,      32'h0,         1'b1, 1};
        tbl[8]  = '{4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1};
        tbl[9]  = '{4'b0001, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1};
        tbl[10] = '{4'b1100, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0,         1'b1, 1};
        tbl[11] = '{4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         1'b0, 33};
        tbl[12] = '{4'b1001, 32'd3,         32'd9,         32'h0,         1'b1, 33};
        tbl[13] = '{4'b1001, 32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFF, 1'b0, 33};

        // reset values
        repeat (2) @(negedge clk);
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset zero", {31'b0, zero}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset in_ready", {31'b0, in_ready}, 32'd1);

        // reset in the middle of a MUL
        in_valid = 1'b1; aluctrl = 4'b1000; a = 32'd1234; b = 32'd5678;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid-mul in_ready", {31'b0, in_ready}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid-mul reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid-mul reset result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after abort in_ready", {31'b0, in_ready}, 32'd1);
        repeat (40) @(negedge clk);
        chk("after abort no output", {31'b0, out_valid}, 32'd0);

        // directed table
        for (int i = 0; i < 14; i++)
            run_and_check($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                          tbl[i].r, tbl[i].z, tbl[i].lat);

        // backpressure: hold result in DONE with in_valid toggling
        @(negedge clk);
        in_valid = 1'b1; aluctrl = 4'b0010; a = 32'd3; b = 32'd4;
        @(posedge clk);
        #1 aluctrl = 4'b0110; a = 32'd100; b = 32'd1;
        @(negedge clk);
        chk("bp out_valid", {31'b0, out_valid}, 32'd1);
        stable = 1'b1;
        rdy_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (result !== 32'd7 || !out_valid) stable = 1'b0;
            if (in_ready) rdy_seen = 1'b1;
        end
        chk("bp result held", {31'b0, stable}, 32'd1);
        chk("bp in_ready low", {31'b0, rdy_seen}, 32'd0);
        in_valid = 1'b1; aluctrl = 4'b0110; a = 32'd100; b = 32'd1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp no accept in handshake", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp in_ready after handshake", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp next op valid", {31'b0, out_valid}, 32'd1);
        chk("bp next op result", result, 32'd99);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // random ops against the reference model
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                  4'b1100, 4'b1000, 4'b1001, 4'b1111, 4'b0011};
        for (int i = 0; i < 40; i++) begin
            k  = $urandom_range(0, 9);
            op = codes[k];
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom) >> $urandom_range(0, 31);
            model(op, ra, rb, er, elat);
            run_and_check($sformatf("rnd%0d op%b", i, op), op, ra, rb, er, (er == 0), elat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
